// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg_pkg;
   localparam int             NUM_DIGITS = 4;
   localparam int             SEG_W      = 8;
   localparam int             IDX_W      = $clog2(NUM_DIGITS);
   localparam int             PAT_W      = NUM_DIGITS * SEG_W;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;
   localparam logic [SEG_W-1:0]      SEG_BLANK = 8'h00;

   typedef logic [IDX_W-1:0] digit_idx_t;
   typedef logic [SEG_W-1:0] seg_t;

   // Pick the segment byte for one digit out of a packed four-digit pattern.
   function automatic seg_t digit_slice(input logic [PAT_W-1:0] pat, input digit_idx_t k);
      return pat[k*SEG_W +: SEG_W];
   endfunction

   // One-hot active-low digit enable for digit k.
   function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_idx_t k);
      return ~(NUM_DIGITS'(1) << k);
   endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index for the scan driver; flags the lit part of a
// slot and the last cycle of a frame.
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   output digit_idx_t idx,
   output logic       visible,
   output logic       boundary
);
   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam digit_idx_t       IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign visible  = (cnt >= CNT_BLANK);
   assign boundary = (cnt == CNT_MAX) && (idx == IDX_LAST);
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: buffers a loaded pattern until
// the frame boundary, then scans it out with blanked, active-low digit enables.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [PAT_W-1:0]      pattern,
   input  logic                  en,
   output logic [SEG_W-1:0]      seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  pending,
   output logic                  frame_tick
);
   digit_idx_t       idx;
   logic             visible;
   logic             boundary;
   logic [PAT_W-1:0] disp;
   logic [PAT_W-1:0] pbuf;

   seg_scan_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .idx      (idx),
      .visible  (visible),
      .boundary (boundary)
   );

   // Commit only at the frame edge so a frame never shows a mix of two patterns;
   // a load landing on the edge itself wins over anything still buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp    <= '0;
         pbuf    <= '0;
         pending <= 1'b0;
      end else if (boundary) begin
         if (load)
            disp <= pattern;
         else if (pending)
            disp <= pbuf;
         pending <= 1'b0;
      end else if (load) begin
         pbuf    <= pattern;
         pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg        <= SEG_BLANK;
         an         <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg        <= digit_slice(disp, idx);
         an         <= (en && visible) ? digit_enable(idx) : AN_OFF;
         frame_tick <= boundary;
      end
   end
endmodule
